// File: rtl/shift_tx_ctrl.sv
// shift_tx_ctrl: serial transmit controller for an external 8-bit shift register.
// It loads a captured byte into the register and then shifts it out LSB first
// on sout, pulsing done once the frame is complete.
// Optional feature: define SHIFT_TX_PARITY_EN to append an even-parity bit
// after the data bits.
module shift_tx_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] din,
   input  logic [7:0] q,
   output logic       S_L,
   output logic       s_in,
   output logic [7:0] p_in,
   output logic       sout,
   output logic       busy,
   output logic       done
);

   localparam int unsigned CNT_W = 3;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      SHIFT = 3'd2,
`ifdef SHIFT_TX_PARITY_EN
      PAR   = 3'd3,
`endif
      DONE  = 3'd4
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic               shift_act;   // sout follows q[0] while shifting
   logic               sout_lvl;    // sout level outside SHIFT

   // The serial fill bit is always zero.
   assign s_in = 1'b0;

   // In SHIFT the register's Q[0] is the current bit; otherwise drive the stored level.
   assign sout = shift_act ? q[0] : sout_lvl;

   // FSM, bit counter, captured byte and registered mode/status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         p_in      <= 8'h00;
         S_L       <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         shift_act <= 1'b0;
         sout_lvl  <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  p_in  <= din;
                  state <= LOAD;
                  S_L   <= 1'b1;
                  busy  <= 1'b1;
               end
            end
            LOAD: begin
               cnt       <= '0;
               state     <= SHIFT;
               S_L       <= 1'b0;
               shift_act <= 1'b1;
            end
            SHIFT: begin
               cnt <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(7)) begin
                  shift_act <= 1'b0;
`ifdef SHIFT_TX_PARITY_EN
                  state    <= PAR;
                  sout_lvl <= ^p_in;
`else
                  state    <= DONE;
                  sout_lvl <= 1'b1;
                  done     <= 1'b1;
`endif
               end
            end
`ifdef SHIFT_TX_PARITY_EN
            PAR: begin
               state    <= DONE;
               sout_lvl <= 1'b1;
               done     <= 1'b1;
            end
`endif
            DONE: begin
               state <= IDLE;
               done  <= 1'b0;
               busy  <= 1'b0;
            end
            default: begin
               state     <= IDLE;
               cnt       <= '0;
               S_L       <= 1'b0;
               busy      <= 1'b0;
               done      <= 1'b0;
               shift_act <= 1'b0;
               sout_lvl  <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_shift_tx_ctrl.sv
// tb_shift_tx_ctrl: directed self-checking bench for shift_tx_ctrl with an
// attached behavioural 8-bit shift register.
`timescale 1ns/1ps
module tb_shift_tx_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] din;
   logic [7:0] q = 8'h00;
   logic       S_L;
   logic       s_in;
   logic [7:0] p_in;
   logic       sout;
   logic       busy;
   logic       done;

   int n_checks = 0;
   int n_pass   = 0;

`ifdef SHIFT_TX_PARITY_EN
   localparam bit PAR_EN = 1'b1;
`else
   localparam bit PAR_EN = 1'b0;
`endif

   shift_tx_ctrl dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .din  (din),
      .q    (q),
      .S_L  (S_L),
      .s_in (s_in),
      .p_in (p_in),
      .sout (sout),
      .busy (busy),
      .done (done)
   );

   always #5 clk = ~clk;

   // Attached shift register: parallel load when S_L, else Q[7:1]->Q[6:0] with s_in into Q[7].
   always @(posedge clk) begin
      if (S_L) q <= p_in;
      else     q <= {s_in, q[7:1]};
   end

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Checks one frame; the caller has already raised start before the sampling edge.
   // seq[k] is the hand-computed sout value in SHIFT cycle k.
   task automatic frame(input logic [7:0] seq, input logic [7:0] cap, input logic par,
                        input bit hold, input bit inject);
      @(negedge clk);                               // cycle n+1: LOAD
      if (!hold) start = 1'b0;
      din = ~cap;                                   // must not disturb the frame
      check("load_sl",   8'(S_L),  8'h01);
      check("load_busy", 8'(busy), 8'h01);
      check("load_pin",  p_in,     cap);
      check("load_sout", 8'(sout), 8'h01);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);                            // cycle n+2+k: SHIFT
         check($sformatf("shift%0d_sout", k), 8'(sout), 8'(seq[k]));
         check($sformatf("shift%0d_sl", k),   8'(S_L),  8'h00);
         check($sformatf("shift%0d_busy", k), 8'(busy), 8'h01);
         check($sformatf("shift%0d_done", k), 8'(done), 8'h00);
         check($sformatf("shift%0d_sin", k),  8'(s_in), 8'h00);
         if (inject && k == 2) begin start = 1'b1; din = 8'hFF; end
         if (inject && k == 3) start = 1'b0;
      end
      if (PAR_EN) begin
         @(negedge clk);                            // cycle n+10: PAR
         check("par_sout", 8'(sout), 8'(par));
         check("par_busy", 8'(busy), 8'h01);
         check("par_sl",   8'(S_L),  8'h00);
         check("par_done", 8'(done), 8'h00);
      end
      @(negedge clk);                               // DONE
      check("done_pulse", 8'(done), 8'h01);
      check("done_busy",  8'(busy), 8'h01);
      check("done_sout",  8'(sout), 8'h01);
      check("done_sl",    8'(S_L),  8'h00);
      @(negedge clk);                               // IDLE gap
      check("idle_done", 8'(done), 8'h00);
      check("idle_busy", 8'(busy), 8'h00);
      check("idle_sout", 8'(sout), 8'h01);
      check("idle_sl",   8'(S_L),  8'h00);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; din = 8'h00;
      repeat (2) @(negedge clk);
      check("rst_busy", 8'(busy), 8'h00);
      check("rst_done", 8'(done), 8'h00);
      check("rst_sout", 8'(sout), 8'h01);
      check("rst_sl",   8'(S_L),  8'h00);
      check("rst_sin",  8'(s_in), 8'h00);
      check("rst_pin",  p_in,     8'h00);
      rst = 1'b0;
      @(negedge clk);

      // Single frame 0x55: sout 1,0,1,0,1,0,1,0; parity 0.
      din = 8'h55; start = 1'b1;
      frame(8'h55, 8'h55, 1'b0, 1'b0, 1'b0);

      // 0xA5 with a start/din=FF attempt mid-frame: sout 1,0,1,0,0,1,0,1 unchanged.
      din = 8'hA5; start = 1'b1;
      frame(8'hA5, 8'hA5, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      check("noqueue_busy", 8'(busy), 8'h00);
      check("noqueue_sl",   8'(S_L),  8'h00);

      // Back-to-back with start held: 0x0F then 0xF0, one IDLE cycle between.
      din = 8'h0F; start = 1'b1;
      frame(8'h0F, 8'h0F, 1'b0, 1'b1, 1'b0);
      din = 8'hF0;
      frame(8'hF0, 8'hF0, 1'b0, 1'b0, 1'b0);

      // Parity vectors: 0x07 has three ones (parity 1), 0x03 has two (parity 0).
      din = 8'h07; start = 1'b1;
      frame(8'h07, 8'h07, 1'b1, 1'b0, 1'b0);
      din = 8'h03; start = 1'b1;
      frame(8'h03, 8'h03, 1'b0, 1'b0, 1'b0);

      // Reset for 2 cycles in the middle of SHIFT aborts the frame.
      din = 8'h3C; start = 1'b1;
      @(negedge clk); start = 1'b0;                 // LOAD
      repeat (3) @(negedge clk);                    // SHIFT k=0..2
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("midrst_busy", 8'(busy), 8'h00);
      check("midrst_done", 8'(done), 8'h00);
      check("midrst_sout", 8'(sout), 8'h01);
      check("midrst_sl",   8'(S_L),  8'h00);
      check("midrst_pin",  p_in,     8'h00);
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check($sformatf("aborted_done%0d", i), 8'(done), 8'h00);
      end

      // Clean frame after abort: 0xC3, parity 0.
      din = 8'hC3; start = 1'b1;
      frame(8'hC3, 8'hC3, 1'b0, 1'b0, 1'b0);

      // Reset in LOAD with start still high: reset wins, back to IDLE.
      din = 8'h81; start = 1'b1;
      @(negedge clk);                               // LOAD
      check("load2_sl", 8'(S_L), 8'h01);
      rst = 1'b1;
      @(negedge clk);
      check("rstload_busy", 8'(busy), 8'h00);
      check("rstload_sl",   8'(S_L),  8'h00);
      check("rstload_pin",  p_in,     8'h00);
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      check("rstload_idle_busy", 8'(busy), 8'h00);
      check("rstload_idle_sl",   8'(S_L),  8'h00);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/shift_tx_ctrl.md
SHIFT_TX_CTRL -- requirements
Module: shift_tx_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous, active-high reset: clk (rising edge) and rst.
REQ-002 Port: clk  input  1  system clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  synchronous active-high reset.
REQ-004 Port: start  input  1  request to transmit din; sampled only in IDLE.
REQ-005 Port: din  input  8  byte to transmit.
REQ-006 Port: q  input  8  Q output of the attached 8-bit shift register.
REQ-007 Port: S_L  output  1  shift-register mode: 1 = parallel load, 0 = shift.
REQ-008 Port: s_in  output  1  serial fill bit to shift register; constant 0.
REQ-009 Port: p_in  output  8  parallel load value to shift register.
REQ-010 Port: sout  output  1  serial line out; idle level 1.
REQ-011 Port: busy  output  1  high from LOAD until DONE inclusive.
REQ-012 Port: done  output  1  one-cycle pulse in DONE.

Function
REQ-013 The FSM SHALL have states IDLE, LOAD, SHIFT, PAR (only with PARITY_EN) and DONE, registered and encoded in 3 bits.
REQ-014 IDLE: S_L=0, busy=0, sout=1; on start=1, the controller SHALL capture din into p_in and go to LOAD.
REQ-015 LOAD (1 cycle): S_L=1, busy=1, sout=1; the shift register loads p_in at the end of this cycle; next state SHIFT, bit counter cleared to 0.
REQ-016 SHIFT (8 cycles): S_L=0, s_in=0, busy=1, sout=q[0]; counter increments every cycle; after count 7, next state PAR if PARITY_EN, else DONE.
REQ-017 Bit order SHALL be LSB first: shift register moves Q[7:1] to Q[6:0], s_in enters Q[7], so SHIFT cycle k presents din[k] on sout.
REQ-018 The bit counter SHALL be 3 bits; the 7->0 wrap SHALL coincide with leaving SHIFT, with no ninth shift.
REQ-019 DONE (1 cycle): done=1, busy=1, S_L=0, sout=1; next state IDLE.
REQ-020 Latency: start sampled at edge n -> LOAD in cycle n+1, din[0] on sout in cycle n+2, done in cycle n+10 (n+11 with PARITY_EN).
REQ-021 start while busy=1 SHALL be ignored and not queued; din changes after capture SHALL NOT affect the frame.
REQ-022 start held high through DONE SHALL begin a new frame on the first IDLE cycle, giving a one-cycle idle gap between frames.
REQ-023 All outputs SHALL be registered or decoded only from state and counter, with no combinational path from start to any output.

Reset
REQ-024 rst=1 at a rising edge SHALL force IDLE, counter=0, p_in=8'h00, S_L=0, s_in=0, sout=1, busy=0, done=0.
REQ-025 Reset mid-frame (any state) SHALL abort the frame with no done pulse; the next start SHALL begin a clean frame.
REQ-026 rst SHALL take priority over start in the same cycle.

Configuration
REQ-027 Macro SHIFT_TX_PARITY_EN defined: the PAR state (1 cycle, busy=1, S_L=0) SHALL drive sout = XOR of the captured byte (even parity) after SHIFT and before DONE.
REQ-028 Macro SHIFT_TX_PARITY_EN undefined: the PAR state and its logic SHALL NOT exist, and SHIFT SHALL go directly to DONE.

Verification
REQ-029 Reset: rst=1 for 2 cycles mid-SHIFT -> next cycle busy=0, done=0, sout=1, S_L=0, p_in=8'h00.
REQ-030 Single frame: din=8'h55, start 1 cycle -> S_L=1 for exactly 1 cycle, p_in=8'h55, then sout=1,0,1,0,1,0,1,0 over 8 cycles, done pulse in cycle n+10.
REQ-031 Ignored start: din=8'hA5 frame, second start with din=8'hFF in cycle n+4 -> sout sequence unchanged (1,0,1,0,0,1,0,1), exactly one done pulse.
REQ-032 Back-to-back: start held high, din=8'h0F then 8'hF0 -> two frames with exactly one IDLE cycle between done and the next LOAD.
REQ-033 Parity build (SHIFT_TX_PARITY_EN): din=8'h07 -> PAR cycle sout=1, and din=8'h03 -> PAR cycle sout=0; done at n+11.
REQ-034 Reset during LOAD with start=1 in the same cycle -> state IDLE, no LOAD next cycle, busy=0.
